// File: rtl/debounce_pkg.sv
// Shared defaults and parameter sanity check for the multi-channel debouncer.
package debounce_pkg;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_STABLE_CYCLES = 20;
    localparam int DEF_LONG_CYCLES   = 1000;

    // True when the channel count and both cycle thresholds fit the counter width.
    function automatic bit params_ok(int channels, int cnt_w, int stable_cycles, int long_cycles);
        longint limit;
        if (cnt_w < 1 || cnt_w > 62) begin
            return 1'b0;
        end
        limit = longint'(1) << cnt_w;
        return (channels >= 1) && (stable_cycles >= 1) && (long_cycles >= 1) &&
               (longint'(stable_cycles) < limit) && (longint'(long_cycles) < limit);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-stage synchroniser, stability filter driving the
// clean level with rise/fall strobes, and a hold counter for the long-press strobe.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic long
);

    localparam logic             ACTIVE_LEVEL = ~IDLE_LEVEL;
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX     = CNT_W'(LONG_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] scnt;
    logic [CNT_W-1:0] hcnt;

    // Synchroniser runs every clock so metastability settling never depends on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Stability filter: any agreement clears the count, a full run of qualified disagreement flips out.
    always_ff @(posedge clk) begin
        if (rst) begin
            out  <= IDLE_LEVEL;
            scnt <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == out) begin
                scnt <= '0;
            end else if (tick) begin
                if (scnt == STABLE_LAST) begin
                    out  <= sync2;
                    scnt <= '0;
                    rise <= sync2;
                    fall <= ~sync2;
                end else begin
                    scnt <= scnt + CNT_W'(1);
                end
            end
        end
    end

    // Hold counter saturates at the threshold so long fires only once per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            long <= 1'b0;
        end else begin
            long <= 1'b0;
            if (out != ACTIVE_LEVEL) begin
                hcnt <= '0;
            end else if (tick && (hcnt != LONG_MAX)) begin
                hcnt <= hcnt + CNT_W'(1);
                long <= (hcnt == LONG_LAST);
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer for a key bank: independent debounce_chan per input bit.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   CNT_W         = DEF_CNT_W,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int   LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter logic IDLE_LEVEL    = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long
);

    // Reject configurations whose thresholds cannot be represented by the counters.
    generate
        if (!params_ok(CHANNELS, CNT_W, STABLE_CYCLES, LONG_CYCLES)) begin : g_bad_params
            $error("debounce_multi: illegal CHANNELS/CNT_W/STABLE_CYCLES/LONG_CYCLES combination");
        end
    endgenerate

    // One fully independent channel per input bit; no shared state between channels.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            debounce_chan #(
                .CNT_W         (CNT_W),
                .STABLE_CYCLES (STABLE_CYCLES),
                .LONG_CYCLES   (LONG_CYCLES),
                .IDLE_LEVEL    (IDLE_LEVEL)
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .tick (tick),
                .in   (in[i]),
                .out  (out[i]),
                .rise (rise[i]),
                .fall (fall[i]),
                .long (long[i])
            );
        end
    endgenerate

endmodule
